// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the serial-load 13x13 multiplier sequencer.
package mul_seq_pkg;

    localparam int unsigned OP_W   = 13;
    localparam int unsigned SR_W   = 16;
    localparam int unsigned PROD_W = 26;
    localparam int unsigned UI_W   = 8;
    localparam int unsigned CNT_W  = 5;

    // ui_in pin positions on the multiplier
    localparam int unsigned MUL_UI_A    = 0;
    localparam int unsigned MUL_UI_B    = 1;
    localparam int unsigned MUL_UI_GATE = 2;
    localparam int unsigned MUL_UI_SEL  = 6;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_SETTLE,
        S_RD_LO,
        S_RD_HI,
        S_DONE
    } state_t;

    typedef struct packed {
        logic            id;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_req_t;

    function automatic logic [SR_W-1:0] zext_op(input logic [OP_W-1:0] x);
        return {{(SR_W - OP_W){1'b0}}, x};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant flop only moves on an accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant_c
);

    // 1 out of reset so requester 0 wins the first tie
    logic last;

    always_comb begin
        grant_c = valid;
        if (valid == 2'b11) begin
            grant_c = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant_c[1];
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer: arbitrates two requesters, shifts operands into the multiplier,
// latches, waits, reads the product back in two halves and returns it tagged.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [PROD_W-1:0] rsp_prod,
    output logic [UI_W-1:0]   mul_ui,
    input  logic [7:0]        mul_uo,
    input  logic [7:0]        mul_uio
);

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [SR_W-1:0]     sh_a, sh_a_d, sh_b, sh_b_d;
    logic [SR_W-1:0]     lo, lo_d;
    logic                id, id_d;
    logic [UI_W-1:0]     mul_ui_d;
    logic                rsp_valid_d, rsp_id_d;
    logic [PROD_W-1:0]   rsp_prod_d;

    logic [1:0]          grant;
    logic                idle, accept;
    op_req_t             op;
    logic [SR_W-1:0]     op_a_ext, op_b_ext;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .accept  (accept),
        .grant_c (grant)
    );

    assign idle       = (state == S_IDLE);
    assign accept     = idle & (|grant);
    assign req0_ready = idle & grant[0];
    assign req1_ready = idle & grant[1];

    assign op       = grant[1] ? {1'b1, req1_a, req1_b} : {1'b0, req0_a, req0_b};
    assign op_a_ext = zext_op(op.a);
    assign op_b_ext = zext_op(op.b);

    // Next state and next registered outputs; mul_ui_d is what the pins show in state_d
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        sh_a_d      = sh_a;
        sh_b_d      = sh_b;
        lo_d        = lo;
        id_d        = id;
        mul_ui_d    = '0;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_prod_d  = rsp_prod;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d            = S_SHIFT;
                    cnt_d              = CNT_W'(SR_W - 1);
                    id_d               = op.id;
                    sh_a_d             = {op_a_ext[SR_W-2:0], 1'b0};
                    sh_b_d             = {op_b_ext[SR_W-2:0], 1'b0};
                    mul_ui_d[MUL_UI_A] = op_a_ext[SR_W-1];
                    mul_ui_d[MUL_UI_B] = op_b_ext[SR_W-1];
                end
            end
            S_SHIFT: begin
                if (cnt == '0) begin
                    state_d               = S_LATCH;
                    mul_ui_d[MUL_UI_GATE] = 1'b1;
                end else begin
                    cnt_d              = cnt - CNT_W'(1);
                    mul_ui_d[MUL_UI_A] = sh_a[SR_W-1];
                    mul_ui_d[MUL_UI_B] = sh_b[SR_W-1];
                    sh_a_d             = {sh_a[SR_W-2:0], 1'b0};
                    sh_b_d             = {sh_b[SR_W-2:0], 1'b0};
                end
            end
            S_LATCH: begin
                mul_ui_d[MUL_UI_SEL] = SEL_LO;
                if (SETTLE_CYC == 0) begin
                    state_d = S_RD_LO;
                    cnt_d   = CNT_W'(READ_LAT);
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_d = S_RD_LO;
                    cnt_d   = CNT_W'(READ_LAT);
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_RD_LO: begin
                if (cnt == '0) begin
                    state_d              = S_RD_HI;
                    cnt_d                = CNT_W'(READ_LAT);
                    lo_d                 = {mul_uio, mul_uo};
                    mul_ui_d[MUL_UI_SEL] = SEL_HI;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_RD_HI: begin
                // uio[7:2] carries no product bits in the high half
                if (cnt == '0) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id;
                    rsp_prod_d  = {mul_uio[1:0], mul_uo, lo};
                end else begin
                    cnt_d                = cnt - CNT_W'(1);
                    mul_ui_d[MUL_UI_SEL] = SEL_HI;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            lo        <= '0;
            id        <= 1'b0;
            mul_ui    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_prod  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sh_a      <= sh_a_d;
            sh_b      <= sh_b_d;
            lo        <= lo_d;
            id        <= id_d;
            mul_ui    <= mul_ui_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_prod  <= rsp_prod_d;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl with a behavioural serial-load latched multiplier as pin model.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [12:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [25:0] rsp_prod;
    logic [7:0]  mul_ui, mul_uo, mul_uio;

    mul_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_prod   (rsp_prod),
        .mul_ui     (mul_ui),
        .mul_uo     (mul_uo),
        .mul_uio    (mul_uio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier pin model: free-running shift registers, edge-captured latch, byte mux
    logic [15:0] sr_a = '0, sr_b = '0, lat_a = '0, lat_b = '0;
    logic [31:0] prod_w;
    always @(posedge clk) begin
        sr_a <= {sr_a[14:0], mul_ui[0]};
        sr_b <= {sr_b[14:0], mul_ui[1]};
        if (mul_ui[2]) begin
            lat_a <= sr_a;
            lat_b <= sr_b;
        end
    end
    assign prod_w  = 32'(lat_a) * 32'(lat_b);
    assign mul_uo  = mul_ui[6] ? prod_w[23:16] : prod_w[7:0];
    assign mul_uio = mul_ui[6] ? {6'b101010, prod_w[25:24]} : prod_w[15:8];

    typedef struct packed {
        logic        id;
        logic [25:0] prod;
    } exp_t;

    typedef struct {
        logic        id;
        logic [12:0] a;
        logic [12:0] b;
        logic [25:0] prod;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];

    int checks = 0, failures = 0;
    int accepts = 0, gate_cnt = 0, sel_cnt = 0, bad_cnt = 0, rsp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One cycle: step to the falling edge, then monitor pins and score responses
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) accepts++;
            if (mul_ui[2]) gate_cnt++;
            if (mul_ui[6]) sel_cnt++;
            if ((mul_ui & 8'hB8) != 8'h00) bad_cnt++;
            if (mul_ui[6] && (mul_ui[2:0] != 3'b000)) bad_cnt++;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_prod", 32'(rsp_prod), 32'(e.prod));
                    rsp_cnt++;
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("rsp_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_op(input logic id, input logic [12:0] a, input logic [12:0] b,
                         input logic [25:0] prod, input bit drain);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (id ? req1_ready : req0_ready) got = 1'b1;
        end
        chk("accept", 32'(got), 32'd1);
        if (got) sb.push_back({id, prod});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (drain) wait_drain(60);
    endtask

    task automatic do_pair(input logic first_id, input logic [12:0] a0, input logic [12:0] b0,
                           input logic [12:0] a1, input logic [12:0] b1,
                           input logic [25:0] p0, input logic [25:0] p1);
        bit   got0, got1, any;
        logic first;
        got0 = 1'b0; got1 = 1'b0; any = 1'b0; first = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = a0; req0_b = b0;
        req1_valid = 1'b1; req1_a = a1; req1_b = b1;
        for (int i = 0; i < 120 && !(got0 && got1); i++) begin
            tick();
            if (!got0 && req0_valid && req0_ready) begin
                sb.push_back({1'b0, p0});
                if (!any) first = 1'b0;
                any = 1'b1; got0 = 1'b1;
                @(posedge clk); #1;
                req0_valid = 1'b0;
            end else if (!got1 && req1_valid && req1_ready) begin
                sb.push_back({1'b1, p1});
                if (!any) first = 1'b1;
                any = 1'b1; got1 = 1'b1;
                @(posedge clk); #1;
                req1_valid = 1'b0;
            end
        end
        chk("pair_accepts", 32'({got0, got1}), 32'd3);
        chk("pair_first_id", 32'(first), 32'(first_id));
        wait_drain(60);
    endtask

    initial begin : main
        bit   got;
        int   acc, lat, stray;

        tbl[0] = '{1'b1, 13'd1,    13'd1,    26'd1};
        tbl[1] = '{1'b0, 13'd8191, 13'd1,    26'd8191};
        tbl[2] = '{1'b1, 13'd4096, 13'd4096, 26'h1000000};
        tbl[3] = '{1'b0, 13'd1234, 13'd5678, 26'd7006652};
        tbl[4] = '{1'b0, 13'd2,    13'd8191, 26'd16382};
        tbl[5] = '{1'b1, 13'd4095, 13'd4095, 26'd16769025};

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("reset_mul_ui", 32'(mul_ui), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_prod", 32'(rsp_prod), 32'd0);
        chk("reset_readies", 32'({req1_ready, req0_ready}), 32'd0);

        // Max operands, with accept-to-valid latency
        got = 1'b0; acc = 0; lat = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 13'h1FFF; req0_b = 13'h1FFF;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (req0_ready) begin
                got = 1'b1;
                acc = cyc + 1;
            end
        end
        chk("lat_accept", 32'(got), 32'd1);
        sb.push_back({1'b0, 26'h3FFC001});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rsp_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd23);
        wait_drain(60);

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].prod, 1'b1);
        end

        // Last grant was requester 1, so the tie goes to requester 0
        do_pair(1'b0, 13'd3, 13'd5, 13'd7, 13'd11, 26'd15, 26'd77);
        do_op(1'b0, 13'd10, 13'd10, 26'd100, 1'b1);
        do_pair(1'b1, 13'd3, 13'd5, 13'd7, 13'd11, 26'd15, 26'd77);

        // Consumer stall: response held, no acceptance, no latch activity
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_op(1'b0, 13'd100, 13'd200, 26'd20000, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (rsp_valid) got = 1'b1;
        end
        chk("hold_rsp_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 13'd8191; req1_b = 13'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_rsp_stable", 32'({rsp_valid, rsp_id, rsp_prod}), 32'({1'b1, 1'b0, 26'd20000}));
            chk("hold_readies", 32'({req1_ready, req0_ready}), 32'd0);
            chk("hold_mul_ui", 32'(mul_ui), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        tick();
        @(posedge clk); #1;
        tick();
        chk("release_accept", 32'(req1_ready), 32'd1);
        if (req1_ready) sb.push_back({1'b1, 26'd8191});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_drain(60);

        // Reset during SHIFT cycle 8 aborts the operation
        got = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 13'h0AB; req0_b = 13'h0CD;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (req0_ready) got = 1'b1;
        end
        chk("abort_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (8) begin
            tick();
            @(posedge clk); #1;
        end
        rst = 1'b1;
        tick();
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        chk("abort_mul_ui", 32'(mul_ui), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid) stray++;
        end
        chk("abort_no_rsp", 32'(stray), 32'd0);

        do_op(1'b0, 13'd0,    13'd4095, 26'd0,    1'b1);
        do_op(1'b0, 13'd4096, 13'd2,    26'd8192, 1'b1);

        // One gate pulse per completed op (the aborted one never reached LATCH)
        chk("gate_pulses", 32'(gate_cnt), 32'(accepts - 1));
        chk("sel_cycles", 32'(sel_cnt), 32'(2 * rsp_cnt));
        chk("bad_ui_bits", 32'(bad_cnt), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
